// File: rtl/systolic_acc_pe.sv
// systolic_acc_pe: output-stationary MAC PE with wide accumulator and drain chain; SYSTOLIC_PE_SAT_EN enables saturation
module systolic_acc_pe #(
  parameter int NBITS = 16,
  parameter int DBITS = 8,
  parameter int SIGN  = 1,
  parameter int ABITS = 32,
  parameter int CBITS = 8,
  parameter int CHAIN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NBITS-1:0] x_in,
  input  logic [NBITS-1:0] w_in,
  input  logic             x_in_val,
  input  logic             w_in_val,
  output logic [NBITS-1:0] x_out,
  output logic [NBITS-1:0] w_out,
  output logic             x_out_val,
  output logic             w_out_val,
  input  logic             clear,
  input  logic             drain,
  input  logic [NBITS-1:0] s_in,
  input  logic             s_in_val,
  output logic [NBITS-1:0] s_out,
  output logic             s_out_val,
  output logic             busy,
  output logic [CBITS-1:0] mac_count,
  output logic             overflow
);
  typedef enum logic {ACC, DRAIN} state_t;
  localparam int KB = (CHAIN > 0) ? $clog2(CHAIN + 1) : 1;
  localparam logic [ABITS:0] HALF = (DBITS > 0) ? {{ABITS{1'b0}}, 1'b1} << ((DBITS > 0) ? DBITS - 1 : 0) : '0;
  state_t state;
  logic [KB-1:0] cnt;
  logic [ABITS-1:0] acc, acc_next, prod_ext, add;
  logic signed [2*NBITS-1:0] ps;
  logic [2*NBITS-1:0] pu;
  logic signed [ABITS-1:0] pse;
  logic [ABITS-1:0] pze;
  logic signed [ABITS:0] rbs;
  logic [ABITS:0] rb, sh_s, sh;
  logic [NBITS-1:0] r;
  logic mac, snap, restart;
  assign mac      = en && x_in_val && w_in_val;
  assign snap     = drain && state == ACC;
  assign restart  = clear || snap;
  assign ps       = $signed(x_in) * $signed(w_in);
  assign pu       = x_in * w_in;
  assign pse      = ps;
  assign pze      = pu;
  assign prod_ext = (SIGN != 0) ? pse : pze;
  assign add      = mac ? prod_ext : '0;
  assign rb       = {(SIGN != 0) && acc[ABITS-1], acc} + HALF;
  assign rbs      = rb;
  assign sh_s     = rbs >>> DBITS;
  assign sh       = (SIGN != 0) ? sh_s : rb >> DBITS;
  assign busy     = state == DRAIN;
`ifdef SYSTOLIC_PE_SAT_EN
  logic [ABITS:0] sum;
  logic [ABITS-1:0] clamp;
  logic acc_ovf, r_hi, r_lo;
  // Accumulate with clamping at the accumulator range, then clamp the rounded result to NBITS
  always_comb begin
    sum     = {(SIGN != 0) && acc[ABITS-1], acc} + {(SIGN != 0) && add[ABITS-1], add};
    acc_ovf = !restart && ((SIGN != 0) ? sum[ABITS] != sum[ABITS-1] : sum[ABITS]);
    clamp   = (SIGN != 0) ? (sum[ABITS] ? {1'b1, {(ABITS-1){1'b0}}} : {1'b0, {(ABITS-1){1'b1}}}) : '1;
    acc_next = restart ? add : acc_ovf ? clamp : sum[ABITS-1:0];
    r_hi    = (SIGN != 0) ? !sh[ABITS] && |sh[ABITS:NBITS-1] : |sh[ABITS:NBITS];
    r_lo    = (SIGN != 0) && sh[ABITS] && !(&sh[ABITS:NBITS-1]);
    r       = r_hi ? ((SIGN != 0) ? {1'b0, {(NBITS-1){1'b1}}} : '1) : r_lo ? {1'b1, {(NBITS-1){1'b0}}} : sh[NBITS-1:0];
  end
  // Sticky flag for any accumulator or result clamp
  always_ff @(posedge clk)
    if (rst) overflow <= 1'b0;
    else if (en) overflow <= overflow || acc_ovf || (snap && (r_hi || r_lo));
`else
  assign acc_next = restart ? add : acc + add;
  assign r        = sh[NBITS-1:0];
  assign overflow = 1'b0;
`endif
  // Operand forwarding, accumulation, MAC counting and drain-chain control
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out <= '0;
      w_out <= '0;
      x_out_val <= 1'b0;
      w_out_val <= 1'b0;
      s_out <= '0;
      s_out_val <= 1'b0;
      mac_count <= '0;
      acc <= '0;
      cnt <= '0;
      state <= ACC;
    end else if (en) begin
      x_out <= x_in;
      w_out <= w_in;
      x_out_val <= x_in_val;
      w_out_val <= w_in_val;
      acc <= acc_next;
      mac_count <= restart ? CBITS'(mac) : (mac && !(&mac_count)) ? mac_count + CBITS'(1) : mac_count;
      if (state == ACC) begin
        s_out_val <= drain;
        if (drain) begin
          s_out <= r;
          cnt <= '0;
          if (CHAIN > 0) state <= DRAIN;
        end
      end else begin
        s_out <= s_in;
        s_out_val <= s_in_val;
        if (s_in_val) begin
          cnt <= cnt + KB'(1);
          if (cnt == KB'(CHAIN - 1)) state <= ACC;
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_acc_pe.sv
// tb_systolic_acc_pe: table-driven checks of a chain-head PE plus directed drain-chain sequences on a CHAIN=2 PE
module tb_systolic_acc_pe;
`ifdef SYSTOLIC_PE_SAT_EN
  localparam logic [15:0] SAT_S = 16'h7FFF;
  localparam logic SAT_O = 1'b1;
`else
  localparam logic [15:0] SAT_S = 16'hFE00;
  localparam logic SAT_O = 1'b0;
`endif
  logic clk = 0, rst = 1, en = 0, xv = 0, wv = 0, clear = 0, drain = 0, siv = 0;
  logic [15:0] x = 0, w = 0, si = 0;
  logic [15:0] xo0, wo0, so0, xo2, wo2, so2;
  logic xov0, wov0, sov0, busy0, ovf0, xov2, wov2, sov2, busy2, ovf2;
  logic [7:0] mc0, mc2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  systolic_acc_pe #(.CHAIN(0)) u0 (.clk(clk), .rst(rst), .en(en), .x_in(x), .w_in(w), .x_in_val(xv), .w_in_val(wv),
    .x_out(xo0), .w_out(wo0), .x_out_val(xov0), .w_out_val(wov0), .clear(clear), .drain(drain), .s_in(si), .s_in_val(siv),
    .s_out(so0), .s_out_val(sov0), .busy(busy0), .mac_count(mc0), .overflow(ovf0));
  systolic_acc_pe #(.CHAIN(2)) u2 (.clk(clk), .rst(rst), .en(en), .x_in(x), .w_in(w), .x_in_val(xv), .w_in_val(wv),
    .x_out(xo2), .w_out(wo2), .x_out_val(xov2), .w_out_val(wov2), .clear(clear), .drain(drain), .s_in(si), .s_in_val(siv),
    .s_out(so2), .s_out_val(sov2), .busy(busy2), .mac_count(mc2), .overflow(ovf2));
  typedef struct {
    logic en, v, clr, drn;
    logic [15:0] x, w, xo, wo, s;
    logic xov, sv;
    logic [7:0] cnt;
  } vec_t;
  vec_t vecs[27];
  function automatic vec_t mk(logic e, logic v, logic c, logic d, logic [15:0] xi, logic [15:0] wi,
                              logic [15:0] xo, logic [15:0] wo, logic xov, logic [15:0] s, logic sv, logic [7:0] cnt);
    mk.en = e; mk.v = v; mk.clr = c; mk.drn = d; mk.x = xi; mk.w = wi;
    mk.xo = xo; mk.wo = wo; mk.xov = xov; mk.s = s; mk.sv = sv; mk.cnt = cnt;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    en = 1; xv = 0; wv = 0; x = 0; w = 0; clear = 0; drain = 0; siv = 0; si = 0;
  endtask
  task automatic do_reset;
    idle;
    rst = 1;
    step;
    rst = 0;
  endtask
  initial begin
    vecs[0]  = mk(1,1,0,0,16'h0180,16'h0200, 16'h0180,16'h0200,1, 16'h0000,0, 1);
    vecs[1]  = mk(1,1,0,0,16'h0180,16'h0200, 16'h0180,16'h0200,1, 16'h0000,0, 2);
    vecs[2]  = mk(1,1,0,0,16'h0180,16'h0200, 16'h0180,16'h0200,1, 16'h0000,0, 3);
    vecs[3]  = mk(1,0,0,1,16'h0000,16'h0000, 16'h0000,16'h0000,0, 16'h0900,1, 0);
    vecs[4]  = mk(1,0,0,0,16'h0000,16'h0000, 16'h0000,16'h0000,0, 16'h0900,0, 0);
    vecs[5]  = mk(1,1,0,0,16'h0100,16'h0200, 16'h0100,16'h0200,1, 16'h0900,0, 1);
    vecs[6]  = mk(0,1,0,0,16'h0300,16'h0300, 16'h0100,16'h0200,1, 16'h0900,0, 1);
    vecs[7]  = mk(0,1,0,0,16'h0300,16'h0300, 16'h0100,16'h0200,1, 16'h0900,0, 1);
    vecs[8]  = mk(1,1,0,0,16'h0300,16'h0100, 16'h0300,16'h0100,1, 16'h0900,0, 2);
    vecs[9]  = mk(1,0,0,1,16'h0000,16'h0000, 16'h0000,16'h0000,0, 16'h0500,1, 0);
    vecs[10] = mk(1,1,0,0,16'h0400,16'h0100, 16'h0400,16'h0100,1, 16'h0500,0, 1);
    vecs[11] = mk(1,1,1,0,16'h0100,16'h0300, 16'h0100,16'h0300,1, 16'h0500,0, 1);
    vecs[12] = mk(1,0,0,1,16'h0000,16'h0000, 16'h0000,16'h0000,0, 16'h0300,1, 0);
    vecs[13] = mk(1,1,1,1,16'h0200,16'h0200, 16'h0200,16'h0200,1, 16'h0000,1, 1);
    vecs[14] = mk(1,0,0,0,16'h0000,16'h0000, 16'h0000,16'h0000,0, 16'h0000,0, 1);
    vecs[15] = mk(1,0,0,1,16'h0000,16'h0000, 16'h0000,16'h0000,0, 16'h0400,1, 0);
    vecs[16] = mk(1,1,0,0,16'h0001,16'h0080, 16'h0001,16'h0080,1, 16'h0400,0, 1);
    vecs[17] = mk(1,0,0,1,16'h0000,16'h0000, 16'h0000,16'h0000,0, 16'h0001,1, 0);
    vecs[18] = mk(1,1,0,0,16'hFF00,16'h0080, 16'hFF00,16'h0080,1, 16'h0001,0, 1);
    vecs[19] = mk(1,0,0,1,16'h0000,16'h0000, 16'h0000,16'h0000,0, 16'hFF80,1, 0);
    vecs[20] = mk(1,1,0,0,16'h0001,16'h007F, 16'h0001,16'h007F,1, 16'hFF80,0, 1);
    vecs[21] = mk(1,0,0,1,16'h0000,16'h0000, 16'h0000,16'h0000,0, 16'h0000,1, 0);
    vecs[22] = mk(1,1,0,0,16'h7FFF,16'h7FFF, 16'h7FFF,16'h7FFF,1, 16'h0000,0, 1);
    vecs[23] = mk(1,1,0,0,16'h7FFF,16'h7FFF, 16'h7FFF,16'h7FFF,1, 16'h0000,0, 2);
    vecs[24] = mk(1,0,0,1,16'h0000,16'h0000, 16'h0000,16'h0000,0, SAT_S,1, 0);
    vecs[25] = mk(0,1,0,1,16'h1234,16'h1234, 16'h0000,16'h0000,0, SAT_S,1, 0);
    vecs[26] = mk(1,0,0,0,16'h0000,16'h0000, 16'h0000,16'h0000,0, SAT_S,0, 0);
    do_reset;
    chk("rst x_out", xo0, 0); chk("rst w_out", wo0, 0); chk("rst s_out", so0, 0);
    chk("rst valids", {xov0, wov0, sov0, xov2, wov2, sov2}, 0);
    chk("rst mac_count", mc0, 0); chk("rst busy", {busy0, busy2}, 0); chk("rst overflow", {ovf0, ovf2}, 0);
    for (int i = 0; i < 27; i++) begin
      en = vecs[i].en; xv = vecs[i].v; wv = vecs[i].v; clear = vecs[i].clr; drain = vecs[i].drn;
      x = vecs[i].x; w = vecs[i].w;
      step;
      chk($sformatf("v%0d x_out", i), xo0, vecs[i].xo);
      chk($sformatf("v%0d w_out", i), wo0, vecs[i].wo);
      chk($sformatf("v%0d xw_val", i), {xov0, wov0}, {vecs[i].xov, vecs[i].xov});
      chk($sformatf("v%0d s_out", i), so0, vecs[i].s);
      chk($sformatf("v%0d s_out_val", i), sov0, vecs[i].sv);
      chk($sformatf("v%0d mac_count", i), mc0, vecs[i].cnt);
      chk($sformatf("v%0d busy", i), busy0, 0);
    end
    chk("overflow flag", ovf0, SAT_O);
    idle; xv = 1; wv = 1;
    for (int i = 0; i < 260; i++) step;
    chk("mac_count saturates", mc0, 8'hFF);
    idle; drain = 1;
    step;
    chk("drain clears mac_count", mc0, 0);
    do_reset;
    xv = 1; wv = 1; x = 16'h0100; w = 16'h0100;
    step;
    idle; drain = 1;
    step;
    chk("chain own s_out", so2, 16'h0100); chk("chain own val", sov2, 1); chk("chain busy rise", busy2, 1);
    si = 16'h1111; siv = 1;
    step;
    chk("chain w1 s_out", so2, 16'h1111); chk("chain w1 val", sov2, 1); chk("chain busy w1", busy2, 1);
    chk("drain ignored when busy", mc2, 0);
    drain = 0; si = 16'hAAAA; siv = 0;
    step;
    chk("chain bubble val", sov2, 0); chk("chain busy bubble", busy2, 1);
    si = 16'h2222; siv = 1;
    step;
    chk("chain w2 s_out", so2, 16'h2222); chk("chain w2 val", sov2, 1); chk("chain busy fall", busy2, 0);
    si = 16'h3333;
    step;
    chk("acc drops s_in val", sov2, 0); chk("acc drops s_in data", so2, 16'h2222);
    do_reset;
    xv = 1; wv = 1; x = 16'h0100; w = 16'h0100;
    step;
    idle; drain = 1;
    step;
    chk("pre-reset busy", busy2, 1);
    idle; rst = 1; si = 16'h4444; siv = 1;
    step;
    chk("mid-drain rst busy", busy2, 0); chk("mid-drain rst val", sov2, 0); chk("mid-drain rst cnt", mc2, 0);
    rst = 0; si = 16'h5555;
    step;
    chk("post-rst s_in dropped", sov2, 0); chk("post-rst busy", busy2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_acc_pe.md
# systolic_acc_pe

Output-stationary systolic processing element with a wide accumulator, valid-tagged operand streams, and a partial-sum drain chain. It is the next-generation PE for the systolic array. Operands flow right/down with validity, and each PE accumulates at full product precision. On a drain token, each PE snapshots its rounded result onto a shift chain and forwards the results of the PEs upstream of it, so a whole column unloads without stalling the next tile.

## Interface
Parameters:
- NBITS, 16: operand and result width (fixed point).
- DBITS, 8: fractional bits of operands and result.
- SIGN, 1: 1 = two's-complement arithmetic, 0 = unsigned.
- ABITS, 32: accumulator width, ≥ 2*NBITS; holds 2*DBITS fractional bits.
- CBITS, 8: mac_count width.
- CHAIN, 0: number of PEs upstream on the drain chain (0 = chain head).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high: one clock; reset is synchronous and active-high.
- en  in  1  global advance. Low = every register holds.
- x_in, w_in  in  NBITS  operands.
- x_in_val, w_in_val  in  1  operand valids.
- x_out, w_out  out  NBITS  registered operand forward.
- x_out_val, w_out_val  out  1  registered valid forward.
- clear  in  1  start a new tile without draining.
- drain  in  1  snapshot the result and start the drain.
- s_in  in  NBITS  upstream drain data.
- s_in_val  in  1  upstream drain valid.
- s_out  out  NBITS  drain chain output.
- s_out_val  out  1  drain chain output valid.
- busy  out  1  high while in state DRAIN.
- mac_count  out  CBITS  MACs accepted since the last clear or drain.
- overflow  out  1  sticky saturation flag.

## Operation
- An accepted MAC is the condition en && x_in_val && w_in_val.
- prod is the full 2*NBITS product, signed if SIGN. It is sign- or zero-extended to ABITS.
- acc_next:
  - If clear or drain is accepted, acc_next = (MAC ? prod : 0).
  - Otherwise, acc_next = acc + (MAC ? prod : 0).
- Forwarding: on every en cycle, x_out/w_out and their valids take x_in/w_in and their valids. Data registers also load while the valid is low.
- mac_count:
  - Increments on each MAC and saturates at all-ones.
  - clear or drain sets it to (MAC ? 1 : 0).
- Result conversion:
  - r = (acc + (DBITS>0 ? 1<<(DBITS-1) : 0)) >> DBITS, arithmetic shift if SIGN.
  - r is then narrowed to NBITS (see Configuration).
- States are ACC (reset state) and DRAIN.
- ACC state:
  - en && drain: s_out <= r(acc), s_out_val <= 1, the accumulator restarts as above, and the forwarded-word counter is cleared.
  - If CHAIN == 0, stay in ACC; otherwise go to DRAIN.
  - Without a drain, s_out_val <= 0.
- DRAIN state, on each en cycle:
  - s_out <= s_in and s_out_val <= s_in_val.
  - Each valid s_in increments the counter.
  - When the CHAIN-th valid word is forwarded, return to ACC.
  - drain is ignored in DRAIN. MACs and clear continue to act on the accumulator, so the next tile overlaps the drain.
- s_in arriving in ACC state is dropped.
- clear and drain together: drain wins; both restart the accumulator identically.

## Timing
- Reset values:
  - x_out, w_out, s_out = 0.
  - All valids = 0.
  - mac_count = 0, overflow = 0, busy = 0.
  - State ACC, counter 0, accumulator 0.
- Reset mid-drain aborts immediately: busy = 0 and s_out_val = 0 the next cycle.
- Operand forward latency is 1 cycle.
- The PE's own result is valid at s_out 1 cycle after drain is accepted.
- Upstream words appear at s_out 1 cycle after s_in.
- s_out_val is a single-cycle pulse per word. There is no backpressure.
- busy asserts the cycle after drain is accepted (CHAIN>0). It deasserts the cycle after the last upstream word is forwarded.
- en low freezes state, counter, accumulator and all outputs, including s_out_val.

## Configuration
- Macro: SYSTOLIC_PE_SAT_EN.
- Defined:
  - The accumulator clamps at the ABITS min/max on overflow.
  - r clamps to the NBITS representable range.
  - Any clamp sets overflow, which stays set until rst.
- Undefined:
  - The accumulator wraps modulo 2^ABITS.
  - r is truncated to its low NBITS bits.
  - overflow is tied to 0.

## Test plan
- Defaults apply unless stated.
- Reset, then 3 MACs of x=0x0180, w=0x0200, then drain → mac_count=3 before the drain; s_out=0x0900 with s_out_val=1 for one cycle after the drain; mac_count=0.
- x/w streams with en low for 2 cycles mid-stream → x_out/w_out/valids hold; the accumulator is unchanged; the sum after resuming matches the reference model.
- CHAIN=2, drain, then s_in valid words 0x1111, a bubble, 0x2222 → s_out sequence: own result, 0x1111, invalid, 0x2222; busy falls the cycle after 0x2222; a drain during busy is ignored.
- clear asserted together with a MAC of 0x0100×0x0300 after a prior accumulation → the next drain yields 0x0300.
- Two MACs of 0x7FFF×0x7FFF, then drain → with SYSTOLIC_PE_SAT_EN: s_out=0x7FFF, overflow=1; without: s_out=0xFE00, overflow=0.
- rst one cycle after a CHAIN=2 drain → busy=0, s_out_val=0, mac_count=0 the next cycle; later upstream s_in words are dropped.
